// File: rtl/key_conditioner.sv
// key_conditioner: synchronizes and debounces active-low push-buttons, and
// produces one-cycle press / release / auto-repeat strobes per key.
module key_conditioner #(
  parameter int NKEYS           = 2,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int HOLD_CYCLES     = 50000000,
  parameter int REPEAT_CYCLES   = 10000000
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [NKEYS-1:0] KEY,
  output logic [NKEYS-1:0] KEY_LEVEL,
  output logic [NKEYS-1:0] KEY_PRESS,
  output logic [NKEYS-1:0] KEY_RELEASE,
  output logic [NKEYS-1:0] KEY_REPEAT
);

  localparam int DB_W   = $clog2(DEBOUNCE_CYCLES);
  localparam int HR_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int HC_W   = $clog2(HR_MAX + 1);

  localparam logic [DB_W-1:0] DB_ZERO   = {DB_W{1'b0}};
  localparam logic [DB_W-1:0] DB_ONE    = DB_W'(1);
  localparam logic [DB_W-1:0] DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HC_W-1:0] HC_ZERO   = {HC_W{1'b0}};
  localparam logic [HC_W-1:0] HC_ONE    = HC_W'(1);
  // A zero hold time disables repeat; the terminal value is then never used.
  localparam logic [HC_W-1:0] HOLD_LAST = HC_W'((HOLD_CYCLES > 0) ? (HOLD_CYCLES - 1) : 0);
  localparam logic [HC_W-1:0] REP_LAST  = HC_W'(REPEAT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HOLD   = 2'd1,
    ST_REPEAT = 2'd2
  } key_state_t;

  logic [NKEYS-1:0] r_sync1;
  logic [NKEYS-1:0] r_sync2;

  // Two-flop synchronizer for the raw asynchronous key pins (idle = released).
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_sync1 <= {NKEYS{1'b1}};
      r_sync2 <= {NKEYS{1'b1}};
    end else begin
      r_sync1 <= KEY;
      r_sync2 <= r_sync1;
    end
  end

  for (genvar gi = 0; gi < NKEYS; gi++) begin : g_key
    logic [DB_W-1:0] r_db_cnt;
    logic            r_level;
    logic            r_press;
    logic            r_release;
    logic            r_repeat;
    key_state_t      r_state;
    key_state_t      w_state_nxt;
    logic [HC_W-1:0] r_hold_cnt;
    logic [HC_W-1:0] w_hold_cnt_nxt;
    logic            w_repeat_nxt;
    logic            w_differs;
    logic            w_accept;
    logic            w_acc_press;
    logic            w_acc_release;

    // A level change is accepted once the synchronized input has differed
    // from the current level for DEBOUNCE_CYCLES consecutive edges.
    assign w_differs     = (r_sync2[gi] != r_level);
    assign w_accept      = w_differs && (r_db_cnt == DB_LAST);
    assign w_acc_press   = w_accept && !r_sync2[gi];
    assign w_acc_release = w_accept &&  r_sync2[gi];

    // Debounce counter, accepted level and press/release strobes.
    always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
        r_db_cnt  <= DB_ZERO;
        r_level   <= 1'b1;
        r_press   <= 1'b0;
        r_release <= 1'b0;
      end else begin
        r_press   <= w_acc_press;
        r_release <= w_acc_release;
        if (!w_differs) begin
          r_db_cnt <= DB_ZERO;
        end else if (w_accept) begin
          r_db_cnt <= DB_ZERO;
          r_level  <= r_sync2[gi];
        end else begin
          r_db_cnt <= r_db_cnt + DB_ONE;
        end
      end
    end

    // Hold/repeat FSM state, hold counter and registered repeat strobe.
    always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
        r_state    <= ST_IDLE;
        r_hold_cnt <= HC_ZERO;
        r_repeat   <= 1'b0;
      end else begin
        r_state    <= w_state_nxt;
        r_hold_cnt <= w_hold_cnt_nxt;
        r_repeat   <= w_repeat_nxt;
      end
    end

    // Next-state logic; an accepted release always wins over a due repeat.
    always_comb begin
      w_state_nxt    = r_state;
      w_hold_cnt_nxt = r_hold_cnt;
      w_repeat_nxt   = 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_acc_press) begin
            w_state_nxt    = ST_HOLD;
            w_hold_cnt_nxt = HC_ZERO;
          end else begin
            w_state_nxt    = ST_IDLE;
          end
        end
        ST_HOLD: begin
          if (w_acc_release) begin
            w_state_nxt    = ST_IDLE;
            w_hold_cnt_nxt = HC_ZERO;
          end else if (HOLD_CYCLES == 0) begin
            w_hold_cnt_nxt = HC_ZERO;
          end else if (r_hold_cnt == HOLD_LAST) begin
            w_state_nxt    = ST_REPEAT;
            w_hold_cnt_nxt = HC_ZERO;
            w_repeat_nxt   = 1'b1;
          end else begin
            w_hold_cnt_nxt = r_hold_cnt + HC_ONE;
          end
        end
        ST_REPEAT: begin
          if (w_acc_release) begin
            w_state_nxt    = ST_IDLE;
            w_hold_cnt_nxt = HC_ZERO;
          end else if (r_hold_cnt == REP_LAST) begin
            w_hold_cnt_nxt = HC_ZERO;
            w_repeat_nxt   = 1'b1;
          end else begin
            w_hold_cnt_nxt = r_hold_cnt + HC_ONE;
          end
        end
        default: begin
          w_state_nxt    = ST_IDLE;
          w_hold_cnt_nxt = HC_ZERO;
        end
      endcase
    end

    assign KEY_LEVEL[gi]   = r_level;
    assign KEY_PRESS[gi]   = r_press;
    assign KEY_RELEASE[gi] = r_release;
    assign KEY_REPEAT[gi]  = r_repeat;
  end

endmodule

// File: tb/tb_key_conditioner.sv
// tb_key_conditioner: directed stimulus, a per-cycle reference model and
// hand-computed literal expectations for key_conditioner.
module tb_key_conditioner;

  localparam int DB   = 4;
  localparam int HOLD = 10;
  localparam int REP  = 3;

  logic       CLK = 1'b0;
  logic       RESET;
  logic [1:0] KEY;
  logic [1:0] KEY_LEVEL;
  logic [1:0] KEY_PRESS;
  logic [1:0] KEY_RELEASE;
  logic [1:0] KEY_REPEAT;

  int n_checks = 0;
  int n_pass   = 0;

  key_conditioner #(
    .NKEYS(2),
    .DEBOUNCE_CYCLES(DB),
    .HOLD_CYCLES(HOLD),
    .REPEAT_CYCLES(REP)
  ) dut (
    .CLK(CLK),
    .RESET(RESET),
    .KEY(KEY),
    .KEY_LEVEL(KEY_LEVEL),
    .KEY_PRESS(KEY_PRESS),
    .KEY_RELEASE(KEY_RELEASE),
    .KEY_REPEAT(KEY_REPEAT)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [1:0] act, input logic [1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  // Raw key samples, oldest first; the last two entries are still in the
  // synchronizer. A level flips when the DB oldest samples all disagree with it.
  logic [1:0] hist[$];
  logic [1:0] m_level, m_press, m_rel, m_rep;
  int         t_press[2];
  int         cyc = 0;
  int         el;
  bit         all_flip;

  always @(negedge CLK) begin
    if (RESET) begin
      hist.delete();
      for (int j = 0; j < DB + 2; j++) hist.push_back(2'b11);
      m_level = 2'b11;
      m_press = 2'b00;
      m_rel   = 2'b00;
      m_rep   = 2'b00;
    end else begin
      cyc++;
      hist.push_back(KEY);
      void'(hist.pop_front());
      m_press = 2'b00;
      m_rel   = 2'b00;
      m_rep   = 2'b00;
      for (int k = 0; k < 2; k++) begin
        all_flip = 1'b1;
        for (int j = 0; j < DB; j++)
          if (hist[j][k] == m_level[k]) all_flip = 1'b0;
        if (all_flip) begin
          m_level[k] = ~m_level[k];
          if (m_level[k] == 1'b0) begin
            m_press[k] = 1'b1;
            t_press[k] = cyc;
          end else begin
            m_rel[k] = 1'b1;
          end
        end else if (m_level[k] == 1'b0 && HOLD > 0) begin
          el = cyc - t_press[k];
          if (el >= HOLD && ((el - HOLD) % REP) == 0) m_rep[k] = 1'b1;
        end
      end
    end
    chk("cyc_level",   KEY_LEVEL,   m_level);
    chk("cyc_press",   KEY_PRESS,   m_press);
    chk("cyc_release", KEY_RELEASE, m_rel);
    chk("cyc_repeat",  KEY_REPEAT,  m_rep);
  end

  // ---------------- directed stimulus ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(negedge CLK);
      #1;
    end
  endtask

  logic [25:0] exp_rep4;
  int          bounce_len[4];
  logic        bounce_val[4];

  initial begin
    RESET = 1'b0;
    KEY   = 2'b11;
    #1;
    RESET = 1'b1;
    KEY   = 2'b00;

    // 1. Reset held with keys pressed
    for (int i = 0; i < 10; i++) begin
      tick(1);
      chk("t1_rst_level", KEY_LEVEL, 2'b11);
      chk("t1_rst_strobes", KEY_PRESS | KEY_RELEASE | KEY_REPEAT, 2'b00);
    end
    RESET = 1'b0;
    tick(5);
    chk("t1_level_edge4", KEY_LEVEL, 2'b11);
    chk("t1_press_edge4", KEY_PRESS, 2'b00);
    tick(1);
    chk("t1_level_edge5", KEY_LEVEL, 2'b00);
    chk("t1_press_edge5", KEY_PRESS, 2'b11);
    chk("t1_model_pin", m_press, 2'b11);
    tick(1);
    chk("t1_press_edge6", KEY_PRESS, 2'b00);

    // release both keys before the next scenario
    KEY = 2'b11;
    tick(8);
    chk("rel_all_level", KEY_LEVEL, 2'b11);

    // 2. Clean press on key 0
    KEY = 2'b10;
    tick(5);
    chk("t2_level_edge4", KEY_LEVEL, 2'b11);
    tick(1);
    chk("t2_level_edge5", KEY_LEVEL, 2'b10);
    chk("t2_press_edge5", KEY_PRESS, 2'b01);
    tick(1);
    chk("t2_press_edge6", KEY_PRESS, 2'b00);
    chk("t2_key1_level",  KEY_LEVEL, 2'b10);

    KEY = 2'b11;
    tick(8);
    chk("t2_released", KEY_LEVEL, 2'b11);

    // 3. Bouncing press on key 0: low 3, high 1, low 2, high 1, then steady low
    bounce_len[0] = 3; bounce_val[0] = 1'b0;
    bounce_len[1] = 1; bounce_val[1] = 1'b1;
    bounce_len[2] = 2; bounce_val[2] = 1'b0;
    bounce_len[3] = 1; bounce_val[3] = 1'b1;
    for (int s = 0; s < 4; s++) begin
      KEY = {1'b1, bounce_val[s]};
      for (int c = 0; c < bounce_len[s]; c++) begin
        tick(1);
        chk("t3_no_press", KEY_PRESS, 2'b00);
      end
    end
    KEY = 2'b10;
    tick(5);
    chk("t3_level_edge4", KEY_LEVEL, 2'b11);
    chk("t3_press_edge4", KEY_PRESS, 2'b00);
    tick(1);
    chk("t3_level_edge5", KEY_LEVEL, 2'b10);
    chk("t3_press_edge5", KEY_PRESS, 2'b01);

    KEY = 2'b11;
    tick(8);

    // 4. Auto-repeat on key 1
    KEY = 2'b01;
    tick(6);
    chk("t4_press", KEY_PRESS, 2'b10);
    exp_rep4 = 26'h2492400;  // bits 10,13,16,19,22,25
    for (int i = 1; i <= 25; i++) begin
      tick(1);
      chk("t4_repeat", KEY_REPEAT, {exp_rep4[i], 1'b0});
    end

    // 5. Release so the accepted release lands on the repeat due at press+31
    KEY = 2'b11;
    tick(5);
    chk("t5_level_before", KEY_LEVEL, 2'b01);
    tick(1);
    chk("t5_release", KEY_RELEASE, 2'b10);
    chk("t5_no_repeat", KEY_REPEAT, 2'b00);
    chk("t5_level", KEY_LEVEL, 2'b11);
    for (int i = 0; i < 10; i++) begin
      tick(1);
      chk("t5_after_repeat", KEY_REPEAT, 2'b00);
      chk("t5_after_release", KEY_RELEASE, 2'b00);
    end

    // 6. Reset while key 0 is in the repeat phase
    KEY = 2'b10;
    tick(6);
    chk("t6_press", KEY_PRESS, 2'b01);
    tick(12);
    RESET = 1'b1;
    #1;
    chk("t6_rst_level", KEY_LEVEL, 2'b11);
    chk("t6_rst_strobes", KEY_PRESS | KEY_RELEASE | KEY_REPEAT, 2'b00);
    tick(1);
    RESET = 1'b0;
    tick(5);
    chk("t6_level_edge4", KEY_LEVEL, 2'b11);
    chk("t6_press_edge4", KEY_PRESS, 2'b00);
    tick(1);
    chk("t6_repress", KEY_PRESS, 2'b01);
    chk("t6_level_edge5", KEY_LEVEL, 2'b10);
    for (int i = 1; i <= 10; i++) begin
      tick(1);
      chk("t6_repeat", KEY_REPEAT, (i == 10) ? 2'b01 : 2'b00);
    end

    tick(2);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
